serial_twos_comp_word: RTL and testbench

- Parametrised, word-framed bit-serial complementer.
- Consumes a WIDTH-bit two's-complement word LSB-first, one bit per valid cycle, and emits the transformed word LSB-first.
- Transform per word: pass, two's-complement negate, or ones' complement.
- Sits between a serial bit source (shift-out stage) and a serial sink; flags overflow and zero per word.

---
 rtl/serial_cmp_pkg.sv | 25 ++
 rtl/serial_word_counter.sv | 38 +++
 rtl/serial_twos_comp_word.sv | 99 +++++++++
 tb/tb_serial_twos_comp_word.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_cmp_pkg.sv
// Shared types for the serial arithmetic family: per-word transform modes and
// the carry-tracking state used by the bit-serial complementer.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_NEG  = 2'b01,
    MODE_ONES = 2'b10
  } mode_e;

  typedef enum logic {
    ST_SEEK = 1'b0,
    ST_FLIP = 1'b1
  } state_e;

  // Encoding 11 is reserved and behaves as pass.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      2'b01:   return MODE_NEG;
      2'b10:   return MODE_ONES;
      default: return MODE_PASS;
    endcase
  endfunction

endpackage

// File: rtl/serial_word_counter.sv
// Bit-index counter for word-framed serial streams: counts accepted bits and
// wraps to 0 after the MSB; is_last flags the MSB position.
module serial_word_counter #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] idx,
  output logic             is_last
);

  logic [CNT_W-1:0] idx_q;
  logic [CNT_W-1:0] idx_d;

  assign is_last = (idx_q == CNT_W'(WIDTH - 1));
  assign idx     = idx_q;

  always_comb begin
    idx_d = idx_q;
    if (clr) begin
      idx_d = '0;
    end else if (en) begin
      idx_d = is_last ? '0 : idx_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/serial_twos_comp_word.sv
// Word-framed bit-serial complementer: pass, two's-complement negate or ones'
// complement of an LSB-first word, with per-word overflow and zero flags.
import serial_cmp_pkg::*;

module serial_twos_comp_word #(
  parameter int unsigned WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       in_valid,
  input  logic       in_bit,
  input  logic [1:0] mode,
  output logic       out_valid,
  output logic       out_bit,
  output logic       out_last,
  output logic       ovf,
  output logic       zero,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [CNT_W-1:0] idx;
  logic             is_last;
  logic             accept;

  state_e state_q;
  mode_e  mode_q;
  mode_e  mode_cur;

  logic out_valid_q, out_bit_q, out_last_q, ovf_q, zero_q;
  logic bit_d, ovf_d, zero_d;

  assign accept = in_valid & ~clr;

  serial_word_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .en      (accept),
    .clr     (clr),
    .idx     (idx),
    .is_last (is_last)
  );

  // The LSB cycle uses the live mode input so the word's first bit is already
  // transformed under the mode being latched on that same cycle.
  assign mode_cur = (idx == '0) ? decode_mode(mode) : mode_q;

  always_comb begin
    bit_d = in_bit;
    case (mode_cur)
      MODE_NEG:  bit_d = (state_q == ST_FLIP) ? ~in_bit : in_bit;
      MODE_ONES: bit_d = ~in_bit;
      default:   bit_d = in_bit;
    endcase
    ovf_d  = is_last & (mode_cur == MODE_NEG) & (state_q == ST_SEEK) & in_bit;
    zero_d = is_last & (state_q == ST_SEEK) & ~in_bit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SEEK;
      mode_q      <= MODE_PASS;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_last_q  <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else if (clr) begin
      state_q     <= ST_SEEK;
      out_valid_q <= 1'b0;
    end else if (in_valid) begin
      out_valid_q <= 1'b1;
      out_bit_q   <= bit_d;
      out_last_q  <= is_last;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      if (idx == '0) begin
        mode_q <= mode_cur;
      end
      if (is_last) begin
        state_q <= ST_SEEK;
      end else if (in_bit) begin
        state_q <= ST_FLIP;
      end
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;
  assign out_last  = out_last_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign busy      = (idx != '0);

endmodule

// File: tb/tb_serial_twos_comp_word.sv
// Directed and randomised bench for serial_twos_comp_word at WIDTH 4, 8 and 16;
// all three instances share one input stream, outputs are selected by width.
module tb_serial_twos_comp_word;

  localparam logic [1:0] M_PASS = 2'b00;
  localparam logic [1:0] M_NEG  = 2'b01;
  localparam logic [1:0] M_ONES = 2'b10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic [1:0] mode = 2'b00;

  logic v4, b4, l4, ov4, z4, bz4;
  logic v8, b8, l8, ov8, z8, bz8;
  logic v16, b16, l16, ov16, z16, bz16;
  logic o_valid, o_bit, o_last, o_ovf, o_zero, o_busy;

  int sel = 4;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_twos_comp_word #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_bit(in_bit), .mode(mode),
    .out_valid(v4), .out_bit(b4), .out_last(l4), .ovf(ov4), .zero(z4), .busy(bz4));
  serial_twos_comp_word #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_bit(in_bit), .mode(mode),
    .out_valid(v8), .out_bit(b8), .out_last(l8), .ovf(ov8), .zero(z8), .busy(bz8));
  serial_twos_comp_word #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_bit(in_bit), .mode(mode),
    .out_valid(v16), .out_bit(b16), .out_last(l16), .ovf(ov16), .zero(z16), .busy(bz16));

  always_comb begin
    case (sel)
      8:       {o_valid, o_bit, o_last, o_ovf, o_zero, o_busy} = {v8, b8, l8, ov8, z8, bz8};
      16:      {o_valid, o_bit, o_last, o_ovf, o_zero, o_busy} = {v16, b16, l16, ov16, z16, bz16};
      default: {o_valid, o_bit, o_last, o_ovf, o_zero, o_busy} = {v4, b4, l4, ov4, z4, bz4};
    endcase
  end

  function automatic logic [15:0] ref_out(input int w, input logic [15:0] word, input logic [1:0] md);
    int unsigned m = (32'd1 << w) - 32'd1;
    int unsigned x = 32'(word) & m;
    case (md)
      M_NEG:   x = (32'd0 - x) & m;
      M_ONES:  x = ~x & m;
      default: x = x;
    endcase
    return 16'(x);
  endfunction

  task automatic apply_reset();
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_bit = 1'b0; mode = M_PASS;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Drives one word (optionally with idle gaps and mode noise after bit 0) and
  // records what the selected DUT produced for each bit.
  task automatic drive_word(input int w, input logic [15:0] word, input logic [1:0] md,
                            input int maxgap, input bit mode_noise,
                            output logic [15:0] res, output logic [15:0] lastm,
                            output int bad_valid, output logic f_ovf, output logic f_zero,
                            output int stray);
    res = '0; lastm = '0; bad_valid = 0; f_ovf = 1'b0; f_zero = 1'b0; stray = 0;
    for (int i = 0; i < w; i++) begin
      int g;
      g = (maxgap > 0 && i > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      for (int k = 0; k < g; k++) begin
        in_valid = 1'b0;
        if (mode_noise) mode = 2'($urandom_range(3, 0));
        @(posedge clk); #1;
        if (o_valid) bad_valid++;
      end
      in_valid = 1'b1;
      in_bit   = word[i];
      mode     = (i == 0 || !mode_noise) ? md : 2'($urandom_range(3, 0));
      @(posedge clk); #1;
      if (!o_valid) bad_valid++;
      res[i]   = o_bit;
      lastm[i] = o_last;
      if (i == w - 1) begin
        f_ovf = o_ovf; f_zero = o_zero;
      end else if (o_ovf || o_zero) begin
        stray++;
      end
    end
  endtask

  task automatic test_reset();
    sel = 4;
    rst = 1'b1;
    #1;
    checks++;
    if ({o_valid, o_bit, o_last, o_ovf, o_zero, o_busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 000000", {o_valid, o_bit, o_last, o_ovf, o_zero, o_busy});
    end
    apply_reset();
  endtask

  task automatic test_negate();
    logic [15:0] r, lm; int bv, st; logic fo, fz;
    sel = 4; apply_reset();
    drive_word(4, 16'b0110, M_NEG, 0, 1'b0, r, lm, bv, fo, fz, st);
    in_valid = 1'b0;
    checks++; if (r[3:0] !== 4'b1010) begin errors++; $display("FAIL neg_0110: got %b want 1010", r[3:0]); end
    checks++; if (lm[3:0] !== 4'b1000) begin errors++; $display("FAIL neg_last: got %b want 1000", lm[3:0]); end
    checks++; if ({fo, fz, bv != 0, st != 0} !== 4'b0000) begin
      errors++; $display("FAIL neg_flags: ovf=%b zero=%b badvalid=%0d stray=%0d want all 0", fo, fz, bv, st);
    end
    @(posedge clk); #1;
    checks++; if ({o_valid, o_last, o_bit} !== 3'b011) begin
      errors++; $display("FAIL idle_hold: valid/last/bit got %b want 011", {o_valid, o_last, o_bit});
    end
  endtask

  task automatic test_ovf();
    logic [15:0] r, lm; int bv, st; logic fo, fz;
    sel = 4; apply_reset();
    drive_word(4, 16'b1000, M_NEG, 0, 1'b0, r, lm, bv, fo, fz, st);
    checks++; if (r[3:0] !== 4'b1000) begin errors++; $display("FAIL ovf_word: got %b want 1000", r[3:0]); end
    checks++; if ({fo, fz} !== 2'b10) begin errors++; $display("FAIL ovf_flags: ovf/zero got %b want 10", {fo, fz}); end
    drive_word(4, 16'b1000, M_PASS, 0, 1'b0, r, lm, bv, fo, fz, st);
    in_valid = 1'b0;
    checks++; if ({r[3:0], fo, fz} !== 6'b100000) begin
      errors++; $display("FAIL pass_no_ovf: word=%b ovf=%b zero=%b want 1000 0 0", r[3:0], fo, fz);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] r, lm; int bv, st; logic fo, fz;
    sel = 4; apply_reset();
    drive_word(4, 16'b0101, M_ONES, 0, 1'b0, r, lm, bv, fo, fz, st);
    checks++; if (r[3:0] !== 4'b1010) begin errors++; $display("FAIL b2b_ones: got %b want 1010", r[3:0]); end
    drive_word(4, 16'b0000, M_NEG, 0, 1'b0, r, lm, bv, fo, fz, st);
    in_valid = 1'b0;
    checks++; if (r[3:0] !== 4'b0000) begin errors++; $display("FAIL b2b_neg0: got %b want 0000", r[3:0]); end
    checks++; if ({fo, fz, lm[3:0]} !== 6'b011000) begin
      errors++; $display("FAIL b2b_flags: ovf=%b zero=%b last=%b want 0 1 1000", fo, fz, lm[3:0]);
    end
  endtask

  task automatic test_gaps();
    logic [15:0] r, lm; int bv, st; logic fo, fz;
    sel = 8; apply_reset();
    drive_word(8, 16'h05, M_NEG, 3, 1'b1, r, lm, bv, fo, fz, st);
    in_valid = 1'b0;
    checks++; if (r[7:0] !== 8'hFB) begin errors++; $display("FAIL gap_neg05: got %h want fb", r[7:0]); end
    checks++; if (bv !== 0) begin errors++; $display("FAIL gap_valid: bad out_valid count %0d want 0", bv); end
    checks++; if (lm[7:0] !== 8'h80) begin errors++; $display("FAIL gap_last: got %b want 10000000", lm[7:0]); end
  endtask

  task automatic test_reset_mid_word();
    logic [15:0] r, lm; int bv, st; logic fo, fz;
    sel = 4; apply_reset();
    mode = M_NEG;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_bit = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++; if ({o_busy, o_valid} !== 2'b11) begin errors++; $display("FAIL pre_rst_busy: busy/valid got %b want 11", {o_busy, o_valid}); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({o_valid, o_bit, o_last, o_ovf, o_zero, o_busy} !== 6'b0) begin
      errors++; $display("FAIL mid_rst_outputs: got %b want 000000", {o_valid, o_bit, o_last, o_ovf, o_zero, o_busy});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive_word(4, 16'b0011, M_NEG, 0, 1'b0, r, lm, bv, fo, fz, st);
    in_valid = 1'b0;
    checks++; if ({r[3:0], lm[3:0]} !== 8'b1101_1000) begin
      errors++; $display("FAIL rst_recover: word=%b last=%b want 1101 1000", r[3:0], lm[3:0]);
    end
  endtask

  task automatic test_clr();
    logic [15:0] r, lm; int bv, st; logic fo, fz;
    sel = 4; apply_reset();
    mode = M_NEG;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_bit = 1'b1;
      @(posedge clk); #1;
    end
    clr = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    checks++; if ({o_busy, o_valid} !== 2'b00) begin errors++; $display("FAIL clr_busy: busy/valid got %b want 00", {o_busy, o_valid}); end
    drive_word(4, 16'b0010, M_NEG, 0, 1'b0, r, lm, bv, fo, fz, st);
    in_valid = 1'b0;
    checks++; if ({r[3:0], lm[3:0]} !== 8'b1110_1000) begin
      errors++; $display("FAIL clr_fresh: word=%b last=%b want 1110 1000", r[3:0], lm[3:0]);
    end
  endtask

  task automatic test_stress();
    logic [15:0] r, lm, w, exp; int bv, st; logic fo, fz; logic [1:0] md;
    int widths[3] = '{4, 8, 16};
    for (int wi = 0; wi < 3; wi++) begin
      int wd;
      int unsigned m;
      wd = widths[wi];
      m = (32'd1 << wd) - 32'd1;
      sel = wd; apply_reset();
      for (int n = 0; n < 1000; n++) begin
        md = 2'($urandom_range(3, 0));
        case (n % 8)
          0:       w = 16'((32'd1 << (wd - 1)) & m);
          1:       w = '0;
          2:       w = 16'(m);
          default: w = 16'($urandom & m);
        endcase
        drive_word(wd, w, md, 1, 1'b0, r, lm, bv, fo, fz, st);
        exp = ref_out(wd, w, md);
        checks++; if ((r & 16'(m)) !== exp) begin
          errors++; $display("FAIL stress_word w=%0d in=%h md=%b: got %h want %h", wd, w, md, r & 16'(m), exp);
        end
        checks++; if (fo !== ((md == M_NEG) && (32'(w) == (32'd1 << (wd - 1))))) begin
          errors++; $display("FAIL stress_ovf w=%0d in=%h md=%b: got %b", wd, w, md, fo);
        end
        checks++; if (fz !== (w == 16'd0)) begin
          errors++; $display("FAIL stress_zero w=%0d in=%h: got %b", wd, w, fz);
        end
        checks++; if ((lm & 16'(m)) !== 16'((32'd1 << (wd - 1)))) begin
          errors++; $display("FAIL stress_last w=%0d: got %b", wd, lm);
        end
        checks++; if (bv != 0 || st != 0) begin
          errors++; $display("FAIL stress_valid w=%0d: badvalid=%0d stray=%0d want 0 0", wd, bv, st);
        end
      end
      in_valid = 1'b0;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_negate();
    test_ovf();
    test_back_to_back();
    test_gaps();
    test_reset_mid_word();
    test_clr();
    test_stress();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
